svc_axi_burst_split_ax: RTL and testbench

SVC_AXI_BURST_SPLIT_AX -- requirements
Module: svc_axi_burst_split_ax

---
 rtl/svc_axi_burst_split_ax.sv | 135 +++++++++++++
 tb/tb_svc_axi_burst_split_ax.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/svc_axi_burst_split_ax.sv
// AXI address-channel burst splitter.
// Each accepted request is issued as one or more sub-bursts. A sub-burst is
// limited by the beats left, by MAX_SUB_BEATS, by the INCR address boundary
// and by the WRAP container end.
module svc_axi_burst_split_ax #(
    parameter int AXI_ADDR_WIDTH = 16,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int MAX_SUB_BEATS  = 1,
    parameter int BOUNDARY_BYTES = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_valid,
    input  logic [AXI_ADDR_WIDTH-1:0] s_addr,
    input  logic [AXI_ID_WIDTH-1:0]   s_id,
    input  logic [7:0]                s_len,
    input  logic [2:0]                s_size,
    input  logic [1:0]                s_burst,
    output logic                      s_ready,
    output logic                      m_valid,
    output logic [AXI_ADDR_WIDTH-1:0] m_addr,
    output logic [AXI_ID_WIDTH-1:0]   m_id,
    output logic [7:0]                m_len,
    output logic [2:0]                m_size,
    output logic [1:0]                m_burst,
    output logic                      m_last,
    input  logic                      m_ready
);
    localparam int AW = AXI_ADDR_WIDTH;
    // One extra bit so that "end of container" and boundary distances
    // never wrap inside the limit arithmetic.
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] BND  = LW'(BOUNDARY_BYTES);
    localparam logic [LW-1:0] MAXB = LW'(MAX_SUB_BEATS);

    typedef enum logic {IDLE, ACTIVE} state_t;
    // Reserved bursts and illegal-length WRAPs are folded into K_INCR.
    typedef enum logic [1:0] {K_FIXED, K_INCR, K_WRAP} kind_t;

    state_t state_q, state_d;
    kind_t  kind_q, kind_in;

    logic [AW-1:0]           addr_q, wrap_lo_q;
    logic [LW-1:0]           wrap_end_q;
    logic [AXI_ID_WIDTH-1:0] id_q;
    logic [2:0]              size_q;
    logic [8:0]              rem_q;

    logic [AW-1:0] span, wrap_lo_in;
    logic [LW-1:0] wrap_end_in;
    logic [LW-1:0] addr_x, lim, n, next_addr;
    logic          last, s_hs, m_hs;

    // Decode the incoming request: effective kind and WRAP container
    always_comb begin
        span        = AW'(9'(s_len) + 9'd1) << s_size;
        wrap_lo_in  = s_addr & ~(span - AW'(1));
        wrap_end_in = {1'b0, wrap_lo_in} + {1'b0, span};
        case (s_burst)
            2'b00:   kind_in = K_FIXED;
            2'b10:   kind_in = (s_len == 8'd1 || s_len == 8'd3 ||
                                s_len == 8'd7 || s_len == 8'd15) ? K_WRAP : K_INCR;
            default: kind_in = K_INCR;
        endcase
    end

    // Size the current sub-burst and compute the address after it
    always_comb begin
        addr_x = {1'b0, addr_q};
        case (kind_q)
            K_INCR:  lim = (BND - (addr_x & (BND - LW'(1)))) >> size_q;
            K_WRAP:  lim = (wrap_end_q - addr_x) >> size_q;
            default: lim = '1;
        endcase
        n = LW'(rem_q);
        if (MAXB < n) n = MAXB;
        if (lim < n)  n = lim;
        next_addr = addr_x + (n << size_q);
        last      = (n == LW'(rem_q));
    end

    assign m_valid = (state_q == ACTIVE);
    assign m_addr  = addr_q;
    assign m_id    = id_q;
    assign m_size  = size_q;
    assign m_len   = m_valid ? 8'(n - LW'(1)) : '0;
    assign m_last  = m_valid & last;
    assign m_burst = (m_valid && kind_q != K_FIXED && n != LW'(1)) ? 2'b01 : 2'b00;
    assign m_hs    = m_valid & m_ready;
    assign s_ready = (state_q == IDLE) | (m_hs & last);
    assign s_hs    = s_valid & s_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state: a new request taken with the final sub-burst keeps us ACTIVE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (s_hs) state_d = ACTIVE;
            ACTIVE:  if (m_hs && last && !s_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture and per-sub-burst address/remaining-beat update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kind_q     <= K_FIXED;
            addr_q     <= '0;
            wrap_lo_q  <= '0;
            wrap_end_q <= '0;
            id_q       <= '0;
            size_q     <= '0;
            rem_q      <= '0;
        end else if (s_hs) begin
            kind_q     <= kind_in;
            addr_q     <= s_addr;
            wrap_lo_q  <= wrap_lo_in;
            wrap_end_q <= wrap_end_in;
            id_q       <= s_id;
            size_q     <= s_size;
            rem_q      <= 9'(s_len) + 9'd1;
        end else if (m_hs) begin
            rem_q <= rem_q - 9'(n);
            if (kind_q == K_WRAP && next_addr == wrap_end_q)
                addr_q <= wrap_lo_q;
            else if (kind_q != K_FIXED)
                addr_q <= next_addr[AW-1:0];
        end
    end
endmodule

// File: tb/tb_svc_axi_burst_split_ax.sv
// Bench for svc_axi_burst_split_ax: two instances (MAX_SUB_BEATS 4 and 1)
// checked against a beat-level model of AXI burst addressing.
module tb_svc_axi_burst_split_ax;
    localparam int AW  = 16;
    localparam int IW  = 4;
    localparam int BND = 4096;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
        logic        last;
        logic [3:0]  id;
        logic [2:0]  size;
    } sub_t;

    logic clk = 1'b0;
    logic rst, sel, s_valid, m_ready;
    logic [AW-1:0] s_addr;
    logic [IW-1:0] s_id;
    logic [7:0]    s_len;
    logic [2:0]    s_size;
    logic [1:0]    s_burst;

    logic          sv_a, mr_a, sr_a, mv_a, ml_a;
    logic [AW-1:0] ma_a;
    logic [IW-1:0] mi_a;
    logic [7:0]    mn_a;
    logic [2:0]    ms_a;
    logic [1:0]    mb_a;
    logic          sv_b, mr_b, sr_b, mv_b, ml_b;
    logic [AW-1:0] ma_b;
    logic [IW-1:0] mi_b;
    logic [7:0]    mn_b;
    logic [2:0]    ms_b;
    logic [1:0]    mb_b;

    logic          o_sready, o_mvalid, o_mlast;
    logic [AW-1:0] o_maddr;
    logic [IW-1:0] o_mid;
    logic [7:0]    o_mlen;
    logic [2:0]    o_msize;
    logic [1:0]    o_mburst;

    int   tests = 0;
    int   fails = 0;
    sub_t exp_q[$];

    always #5 clk = ~clk;

    assign sv_a = s_valid & ~sel;
    assign mr_a = m_ready & ~sel;
    assign sv_b = s_valid & sel;
    assign mr_b = m_ready & sel;

    always_comb begin
        o_sready = sel ? sr_b : sr_a;
        o_mvalid = sel ? mv_b : mv_a;
        o_mlast  = sel ? ml_b : ml_a;
        o_maddr  = sel ? ma_b : ma_a;
        o_mid    = sel ? mi_b : mi_a;
        o_mlen   = sel ? mn_b : mn_a;
        o_msize  = sel ? ms_b : ms_a;
        o_mburst = sel ? mb_b : mb_a;
    end

    svc_axi_burst_split_ax #(.AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW),
                             .MAX_SUB_BEATS(4), .BOUNDARY_BYTES(BND)) u_dut4 (
        .clk(clk), .rst(rst), .s_valid(sv_a), .s_addr(s_addr), .s_id(s_id),
        .s_len(s_len), .s_size(s_size), .s_burst(s_burst), .s_ready(sr_a),
        .m_valid(mv_a), .m_addr(ma_a), .m_id(mi_a), .m_len(mn_a), .m_size(ms_a),
        .m_burst(mb_a), .m_last(ml_a), .m_ready(mr_a));

    svc_axi_burst_split_ax #(.AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW),
                             .MAX_SUB_BEATS(1), .BOUNDARY_BYTES(BND)) u_dut1 (
        .clk(clk), .rst(rst), .s_valid(sv_b), .s_addr(s_addr), .s_id(s_id),
        .s_len(s_len), .s_size(s_size), .s_burst(s_burst), .s_ready(sr_b),
        .m_valid(mv_b), .m_addr(ma_b), .m_id(mi_b), .m_len(mn_b), .m_size(ms_b),
        .m_burst(mb_b), .m_last(ml_b), .m_ready(mr_b));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_group(input int start, input int cnt, input bit last,
                              input bit fixed_b, input int id, input int size);
        sub_t e;
        e.addr  = 16'(start);
        e.len   = 8'(cnt - 1);
        e.burst = (fixed_b || cnt == 1) ? 2'b00 : 2'b01;
        e.last  = last;
        e.id    = 4'(id);
        e.size  = 3'(size);
        exp_q.push_back(e);
    endtask

    // Walk the beats as AXI addresses them, starting a new group when the
    // group is full, when an INCR beat enters a new boundary region, or when
    // a WRAP beat wraps back to the container base.
    task automatic build(input int addr, input int id, input int len, input int size,
                         input int burst, input int maxb);
        int beats, bytes, span, lo, gstart, gcnt, prev, a;
        bit fixed_b, wrap_b, brk;
        beats   = len + 1;
        bytes   = 1 << size;
        fixed_b = (burst == 0);
        wrap_b  = (burst == 2) && (len == 1 || len == 3 || len == 7 || len == 15);
        span    = beats * bytes;
        lo      = wrap_b ? (addr / span) * span : 0;
        gstart  = 0;
        gcnt    = 0;
        prev    = 0;
        for (int i = 0; i < beats; i++) begin
            if (fixed_b)     a = addr;
            else if (wrap_b) a = lo + ((addr - lo + i * bytes) % span);
            else             a = (addr + i * bytes) % 65536;
            brk = (gcnt == maxb);
            if (i > 0 && !fixed_b)
                brk = brk || (wrap_b ? (a == lo) : (a / BND != prev / BND));
            if (i > 0 && brk) begin
                push_group(gstart, gcnt, 1'b0, fixed_b, id, size);
                gcnt = 0;
            end
            if (gcnt == 0) gstart = a;
            gcnt++;
            prev = a;
        end
        push_group(gstart, gcnt, 1'b1, fixed_b, id, size);
    endtask

    task automatic send(input int addr, input int id, input int len, input int size,
                        input int burst);
        @(negedge clk);
        s_valid = 1'b1;
        s_addr  = 16'(addr);
        s_id    = 4'(id);
        s_len   = 8'(len);
        s_size  = 3'(size);
        s_burst = 2'(burst);
        m_ready = 1'b0;
        #1;
        chk("s_ready_idle", o_sready, 1'b1);
        chk("m_valid_idle", o_mvalid, 1'b0);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    // Consume expected sub-bursts; optionally stall one sub-burst for three
    // cycles and present the next request alongside the final sub-burst.
    task automatic drain(input int stall_pct, input int stall_sub, input bit have_next,
                         input int n_addr, input int n_id, input int n_len,
                         input int n_size, input int n_burst);
        int   guard, sub, stall_cnt;
        bit   hold_v, next_sent;
        sub_t f;
        logic [39:0] cur, hold;
        guard = 0; sub = 0; stall_cnt = 0; hold_v = 0; hold = '0;
        next_sent = !have_next;
        while (exp_q.size() > 0 && guard < 5000) begin
            guard++;
            f = exp_q[0];
            if (sub == stall_sub && stall_cnt < 3) begin
                m_ready = 1'b0;
                stall_cnt++;
            end else begin
                m_ready = ($urandom_range(99) >= stall_pct);
            end
            if (!next_sent && f.last) begin
                m_ready = 1'b1;
                s_valid = 1'b1;
                s_addr  = 16'(n_addr);
                s_id    = 4'(n_id);
                s_len   = 8'(n_len);
                s_size  = 3'(n_size);
                s_burst = 2'(n_burst);
            end
            #1;
            cur = {o_maddr, o_mlen, o_mburst, o_mlast, o_mid, o_msize, 4'h0};
            chk("m_valid", o_mvalid, 1'b1);
            chk("m_addr", o_maddr, f.addr);
            chk("m_len", o_mlen, f.len);
            chk("m_burst", o_mburst, f.burst);
            chk("m_last", o_mlast, f.last);
            chk("m_id", o_mid, f.id);
            chk("m_size", o_msize, f.size);
            chk("s_ready_busy", o_sready, m_ready && f.last);
            if (hold_v) chk("m_stable", cur, hold);
            if (m_ready) begin
                void'(exp_q.pop_front());
                sub++;
                hold_v = 0;
                if (s_valid) next_sent = 1;
            end else begin
                hold   = cur;
                hold_v = 1;
            end
            @(negedge clk);
            s_valid = 1'b0;
        end
        chk("drain_timeout", guard < 5000, 1'b1);
        exp_q.delete();
    endtask

    task automatic do_req(input int addr, input int id, input int len, input int size,
                          input int burst, input int stall_pct);
        build(addr, id, len, size, burst, sel ? 1 : 4);
        send(addr, id, len, size, burst);
        drain(stall_pct, -1, 1'b0, 0, 0, 0, 0, 0);
        m_ready = 1'b0;
        #1;
        chk("m_valid_after", o_mvalid, 1'b0);
    endtask

    initial begin
        int sz, bt, ln, ad, idv;
        rst = 1'b1; sel = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        s_addr = '0; s_id = '0; s_len = '0; s_size = '0; s_burst = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_m_valid", {mv_a, mv_b}, 2'b00);
        chk("rst_m_last", {ml_a, ml_b}, 2'b00);
        chk("rst_m_fields", {ma_a, mn_a, mb_a, mi_a, ms_a}, '0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("s_ready_post_rst", {sr_a, sr_b}, 2'b11);

        // Single-beat splitting of a 4-beat INCR
        sel = 1'b1;
        do_req('hA000, 'hD, 3, 1, 1, 0);
        sel = 1'b0;
        // Boundary crossing, WRAP container, FIXED
        do_req('h0FF8, 5, 7, 2, 1, 0);
        do_req('h0038, 6, 7, 3, 2, 0);
        do_req('h1234, 7, 5, 0, 0, 0);

        // Stall mid-burst, then a back-to-back request with the last sub-burst
        build('h0FF8, 9, 7, 2, 1, 4);
        build('h2000, 3, 5, 1, 1, 4);
        send('h0FF8, 9, 7, 2, 1);
        drain(0, 1, 1'b1, 'h2000, 3, 5, 1, 1);
        m_ready = 1'b0;
        #1;
        chk("m_valid_after_b2b", o_mvalid, 1'b0);

        // Reset during the second sub-burst
        send('h0FF8, 2, 7, 2, 1);
        m_ready = 1'b1;
        #1;
        chk("rst_mid_first", o_maddr, 16'h0FF8);
        @(negedge clk);
        m_ready = 1'b0;
        #1;
        chk("rst_mid_second_valid", o_mvalid, 1'b1);
        chk("rst_mid_second_addr", o_maddr, 16'h1000);
        rst = 1'b1;
        #1;
        chk("rst_mid_m_valid", o_mvalid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_s_ready", o_sready, 1'b1);
        m_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_mid_discarded", o_mvalid, 1'b0);
        do_req('h0FF8, 2, 7, 2, 1, 0);

        // Randomized requests on both instances with random back-pressure
        for (int r = 0; r < 60; r++) begin
            sz  = $urandom_range(3);
            bt  = $urandom_range(3);
            idv = $urandom_range(15);
            if (bt == 2 && $urandom_range(3) != 0) ln = (2 << $urandom_range(3)) - 1;
            else if ($urandom_range(3) == 0)       ln = $urandom_range(255);
            else                                   ln = $urandom_range(15);
            ad = $urandom_range(65535);
            if ($urandom_range(1) == 1) ad = ad | 'h0F80;
            ad  = ad & ~((1 << sz) - 1);
            sel = (r % 4 == 3);
            do_req(ad, idv, ln, sz, bt, 25);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
